// File: rtl/melody_sequencer_pkg.sv
// melody_sequencer_pkg: shared FSM states, note entry type, note dividers and song ROM
//   Package melody_pkg: DIV_W/DUR_W field widths, state_t, note_entry_t {div, dur},
//   NOTE_C4..NOTE_C6 half-period dividers at 50 MHz, NOTE_REST, song_rom(song, idx).
//   A dur of 0 marks the end of a song; song 1 is a short four-entry phrase.
package melody_pkg;
  localparam int SYS_CLK_HZ = 50_000_000;
  localparam int DIV_W = 18;
  localparam int DUR_W = 4;
  typedef enum logic [2:0] {IDLE, FETCH, HANDOFF, PLAY, GAP, ADVANCE, END} state_t;
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DUR_W-1:0] dur;
  } note_entry_t;
  function automatic logic [DIV_W-1:0] hz_div(int hz);
    return DIV_W'(SYS_CLK_HZ / (2 * hz));
  endfunction
  localparam logic [DIV_W-1:0] NOTE_REST = '0;
  localparam logic [DIV_W-1:0] NOTE_C4 = hz_div(262);
  localparam logic [DIV_W-1:0] NOTE_D4 = hz_div(294);
  localparam logic [DIV_W-1:0] NOTE_E4 = hz_div(330);
  localparam logic [DIV_W-1:0] NOTE_F4 = hz_div(349);
  localparam logic [DIV_W-1:0] NOTE_G4 = hz_div(392);
  localparam logic [DIV_W-1:0] NOTE_A4 = hz_div(440);
  localparam logic [DIV_W-1:0] NOTE_B4 = hz_div(494);
  localparam logic [DIV_W-1:0] NOTE_C5 = hz_div(523);
  localparam logic [DIV_W-1:0] NOTE_C6 = hz_div(1047);
  function automatic note_entry_t song_rom(int song, int idx);
    note_entry_t e;
    e = '0;
    if (song == 1)
      case (idx)
        0: e = '{DIV_W'(100), 4'd2};
        1: e = '{NOTE_REST, 4'd1};
        2: e = '{DIV_W'(50), 4'd1};
        default: e = '0;
      endcase
    else
      case (idx)
        0, 1, 6: e = '{NOTE_E4, 4'd4};
        2, 5: e = '{NOTE_F4, 4'd4};
        3, 4, 15: e = '{NOTE_G4, 4'd4};
        7, 10: e = '{NOTE_D4, 4'd4};
        8, 9: e = '{NOTE_C4, 4'd4};
        11: e = '{NOTE_E4, 4'd4};
        12: e = '{NOTE_E4, 4'd6};
        13: e = '{NOTE_D4, 4'd2};
        14: e = '{NOTE_D4, 4'd8};
        16: e = '{NOTE_A4, 4'd4};
        17: e = '{NOTE_B4, 4'd4};
        18: e = '{NOTE_C5, 4'd4};
        19: e = '{NOTE_C6, 4'd8};
        20: e = '{NOTE_REST, 4'd4};
        default: e = '0;
      endcase
    return e;
  endfunction
endpackage

// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: note handoff channel from the sequencer to the tone generator
//   note_div (half-period divider, 0 = rest), note_valid, note_ready.
//   master = sequencer side, slave = tone generator side.
interface melody_sequencer_if;
  import melody_pkg::*;
  logic [DIV_W-1:0] note_div;
  logic note_valid;
  logic note_ready;
  modport master (output note_div, note_valid, input note_ready);
  modport slave (input note_div, note_valid, output note_ready);
endinterface

// File: rtl/melody_sequencer_tempo_tick.sv
// tempo_tick: tempo prescaler emitting a one-cycle tick every PERIOD cycles
//   clk, rst (async high); en_i (0 holds count at 0); clr_i (restart period); tick_o.
module tempo_tick #(
  parameter int PERIOD = 3_125_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = en_i && cnt_q == W'(PERIOD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= (clr_i || !en_i || tick_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a song ROM at tempo, hands notes to the tone generator, gates tone_en
//   Ports: clk, rst (async high); start_i, stop_i (pulses); loop_en_i; bus (master: note_div,
//   note_valid out, note_ready in); tone_en_o; note_idx_o; busy_o; done_o (one-shot completion).
//   Build option MELODY_TRANSPOSE_EN adds octave_shift_i[1:0]; note_div = ROM div >> octave_shift_i.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 16,
  parameter int SONG_LEN = 32,
  parameter int GAP_TICKS = 1,
  parameter int SONG_ID = 0,
  localparam int IDX_W = SONG_LEN > 1 ? $clog2(SONG_LEN) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic stop_i,
  input  logic loop_en_i,
`ifdef MELODY_TRANSPOSE_EN
  input  logic [1:0] octave_shift_i,
`endif
  melody_sequencer_if.master bus,
  output logic tone_en_o,
  output logic [IDX_W-1:0] note_idx_o,
  output logic busy_o,
  output logic done_o
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d, rom_div;
  logic valid_q, valid_d, tone_q, tone_d, done_q, done_d;
  logic tick, accept;
  note_entry_t entry;
  assign entry = int'(idx_q) < SONG_LEN ? song_rom(SONG_ID, int'(idx_q)) : '0;
`ifdef MELODY_TRANSPOSE_EN
  assign rom_div = entry.div >> octave_shift_i;
`else
  assign rom_div = entry.div;
`endif
  // clearing on accept makes every note's first tick a full tempo period
  assign accept = state_q == HANDOFF && bus.note_ready;
  tempo_tick #(.PERIOD(CLK_HZ / TICK_HZ)) u_tick (
    .clk(clk),
    .rst(rst),
    .en_i(state_q != IDLE),
    .clr_i(accept),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    div_d = div_q;
    valid_d = valid_q;
    tone_d = tone_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = FETCH;
        idx_d = '0;
      end
      FETCH: if (entry.dur == '0) state_d = END;
      else begin
        div_d = rom_div;
        valid_d = 1'b1;
        state_d = HANDOFF;
      end
      HANDOFF: if (accept) begin
        valid_d = 1'b0;
        cnt_d = entry.dur;
        tone_d = div_q != '0;
        state_d = PLAY;
      end
      PLAY: if (tick) begin
        cnt_d = cnt_q == 1 ? DUR_W'(GAP_TICKS) : cnt_q - 1'b1;
        tone_d = cnt_q != 1;
        state_d = cnt_q != 1 ? PLAY : GAP_TICKS == 0 ? ADVANCE : GAP;
      end
      GAP: if (tick) begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == 1 ? ADVANCE : GAP;
      end
      ADVANCE: if (idx_q == IDX_W'(SONG_LEN - 1)) state_d = END;
      else begin
        idx_d = idx_q + 1'b1;
        state_d = FETCH;
      end
      END: if (loop_en_i) begin
        idx_d = '0;
        state_d = FETCH;
      end else begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // stop overrides everything, including a same-cycle start or song completion
    if (stop_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      tone_d = 1'b0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      div_q <= '0;
      valid_q <= 1'b0;
      tone_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      valid_q <= valid_d;
      tone_q <= tone_d;
      done_q <= done_d;
    end
  assign bus.note_div = div_q;
  assign bus.note_valid = valid_q;
  assign tone_en_o = tone_q;
  assign note_idx_o = idx_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: randomized self-checking bench against a per-cycle song timeline model
module tb_melody_sequencer;
  import melody_pkg::*;
  localparam int P = 4;
  localparam int LEN = 4;
  localparam int G = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop_en = 1'b0;
  logic tone_en, busy, done;
  logic [1:0] note_idx;
  int sh = 0;
`ifdef MELODY_TRANSPOSE_EN
  logic [1:0] oct = 2'd0;
`endif
  melody_sequencer_if bus ();
  melody_sequencer #(
    .CLK_HZ(16), .TICK_HZ(4), .SONG_LEN(LEN), .GAP_TICKS(G), .SONG_ID(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .stop_i(stop),
    .loop_en_i(loop_en),
`ifdef MELODY_TRANSPOSE_EN
    .octave_shift_i(oct),
`endif
    .bus(bus),
    .tone_en_o(tone_en),
    .note_idx_o(note_idx),
    .busy_o(busy),
    .done_o(done)
  );
  always #5 clk = ~clk;
  int pass_n = 0;
  int total_n = 0;
  int rom_div [LEN] = '{100, 0, 50, 0};
  int rom_dur [LEN] = '{2, 1, 1, 0};
  typedef struct {
    bit rdy;
    bit lp;
    bit tone;
    bit busy;
    bit done;
    bit valid;
    int div;
    int idx;
  } cyc_t;
  cyc_t q[$];
  function automatic void push(bit rdy, bit lp, bit tone, bit bsy, bit dn, bit vld, int dv, int ix);
    q.push_back('{rdy, lp, tone, bsy, dn, vld, dv, ix});
  endfunction
  // Expected per-cycle outputs after the start edge: one cycle per fetch/advance/end,
  // w+1 handoff cycles, dur*P tone cycles, G*P gap cycles; idx -1 = not checked.
  task automatic build(int passes, int wmax, int w0, int shift);
    int hs;
    hs = 0;
    q.delete();
    for (int p = 0; p < passes; p++) begin
      bit lp;
      int last;
      lp = p < passes - 1;
      last = 0;
      for (int i = 0; i < LEN; i++) begin
        int w, dv;
        last = i;
        push(0, lp, 0, 1, 0, 0, 0, i);
        if (rom_dur[i] == 0) break;
        dv = rom_div[i] >> shift;
        w = (hs == 0 && w0 >= 0) ? w0 : int'($urandom_range(0, wmax));
        hs++;
        for (int k = 0; k <= w; k++) push(k == w, lp, 0, 1, 0, 1, dv, i);
        repeat (rom_dur[i] * P) push(0, lp, dv != 0, 1, 0, 0, dv, i);
        repeat (G * P) push(0, lp, 0, 1, 0, 0, dv, i);
        push(0, lp, 0, 1, 0, 0, dv, i);
      end
      push(0, lp, 0, 1, 0, 0, 0, last);
    end
    push(0, 0, 0, 0, 1, 0, 0, -1);
    push(0, 0, 0, 0, 0, 0, 0, -1);
  endtask
  task automatic run(string name, int abort_at, bit use_rst);
    @(negedge clk);
    start = 1'b1;
    stop = 1'b0;
    bus.note_ready = 1'b0;
    loop_en = q[0].lp;
    for (int c = 0; c < q.size(); c++) begin
      cyc_t e;
      @(negedge clk);
      e = q[c];
      total_n++;
      if (tone_en !== e.tone || busy !== e.busy || done !== e.done || bus.note_valid !== e.valid ||
          (e.idx >= 0 && note_idx !== 2'(e.idx)) || (e.valid && bus.note_div !== DIV_W'(e.div)))
        $display("FAIL %s cyc %0d: got tone=%b busy=%b done=%b valid=%b idx=%0d div=%0d, want tone=%b busy=%b done=%b valid=%b idx=%0d div=%0d",
                 name, c, tone_en, busy, done, bus.note_valid, note_idx, bus.note_div,
                 e.tone, e.busy, e.done, e.valid, e.idx, e.div);
      else pass_n++;
      bus.note_ready = e.rdy;
      loop_en = e.lp;
      start = e.busy ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (c == abort_at) begin
        if (use_rst) begin
          start = 1'b0;
          #2 rst = 1'b1;
          #1 total_n++;
          if ({tone_en, busy, done, bus.note_valid} !== 4'b0 || bus.note_div !== '0 || note_idx !== '0)
            $display("FAIL %s async_rst: got tone=%b busy=%b done=%b valid=%b div=%0d idx=%0d, want all 0",
                     name, tone_en, busy, done, bus.note_valid, bus.note_div, note_idx);
          else pass_n++;
          @(negedge clk) rst = 1'b0;
        end else begin
          stop = 1'b1;
          start = 1'($urandom_range(0, 1));
          @(negedge clk);
          stop = 1'b0;
          start = 1'b0;
          bus.note_ready = 1'b0;
          total_n++;
          if ({tone_en, busy, done, bus.note_valid} !== 4'b0)
            $display("FAIL %s stop: got tone=%b busy=%b done=%b valid=%b, want 0000",
                     name, tone_en, busy, done, bus.note_valid);
          else pass_n++;
          repeat (3) @(negedge clk);
          total_n++;
          if ({tone_en, busy, done, bus.note_valid} !== 4'b0)
            $display("FAIL %s after_stop: got tone=%b busy=%b done=%b valid=%b, want 0000",
                     name, tone_en, busy, done, bus.note_valid);
          else pass_n++;
        end
        return;
      end
    end
  endtask
  task automatic test_reset();
    bus.note_ready = 1'b0;
    #3 total_n++;
    if ({tone_en, busy, done, bus.note_valid} !== 4'b0 || bus.note_div !== '0 || note_idx !== '0)
      $display("FAIL reset: got tone=%b busy=%b done=%b valid=%b div=%0d idx=%0d, want all 0",
               tone_en, busy, done, bus.note_valid, bus.note_div, note_idx);
    else pass_n++;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    total_n++;
    if ({tone_en, busy, done, bus.note_valid} !== 4'b0 || note_idx !== '0)
      $display("FAIL reset_idle: got tone=%b busy=%b done=%b valid=%b idx=%0d, want all 0",
               tone_en, busy, done, bus.note_valid, note_idx);
    else pass_n++;
  endtask
  task automatic test_one_shot();
    build(1, 0, 0, sh);
    run("one_shot", -1, 0);
  endtask
  task automatic test_ready_stall();
    build(1, 3, 10, sh);
    run("ready_stall", -1, 0);
  endtask
  task automatic test_loop();
    build(2, 2, -1, sh);
    run("loop", -1, 0);
  endtask
  task automatic test_stop();
    build(1, 0, 0, sh);
    run("stop_play", 4, 0);
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    total_n++;
    if (busy !== 1'b0 || bus.note_valid !== 1'b0)
      $display("FAIL start_stop_same: got busy=%b valid=%b, want 0 0", busy, bus.note_valid);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_stop_idle: got busy=%b done=%b, want 0 0", busy, done);
    else pass_n++;
  endtask
  task automatic test_async_reset();
    build(1, 0, 0, sh);
    run("gap_rst", 33, 1);
    build(1, 2, -1, sh);
    run("replay", -1, 0);
  endtask
  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      build(1 + r % 2, 3, -1, sh);
      run("back_to_back", -1, 0);
    end
  endtask
`ifdef MELODY_TRANSPOSE_EN
  task automatic test_transpose();
    oct = 2'd2;
    sh = 2;
    build(1, 1, -1, sh);
    run("octave2", -1, 0);
    oct = 2'($urandom_range(0, 3));
    sh = int'(oct);
    build(1, 1, -1, sh);
    run("octave_rand", -1, 0);
    oct = 2'd0;
    sh = 0;
  endtask
`endif
  initial begin
    test_reset();
    test_one_shot();
    test_ready_stall();
    test_loop();
    test_stop();
    test_async_reset();
    test_back_to_back();
`ifdef MELODY_TRANSPOSE_EN
    test_transpose();
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
